// File: rtl/hk_pkg.sv
// Shared definitions for the H/K constant-memory fetch sequencer:
// FSM encoding, bank selector values, table sizes and the H slot insert helper.
package hk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_MEM = 3'd1,
    LOAD_H   = 3'd2,
    STREAM_K = 3'd3,
    FINISH   = 3'd4
  } hk_state_e;

  localparam logic HSEL  = 1'b0;
  localparam logic KSEL  = 1'b1;
  localparam int   NUM_H = 8;
  localparam int   NUM_K = 64;

  // Slot 0 (H0) occupies the most significant word.
  function automatic logic [255:0] put_h_word(input logic [255:0] words,
                                              input logic [2:0]   slot,
                                              input logic [31:0]  data);
    logic [255:0] r;
    r = words;
    for (int i = 0; i < NUM_H; i++) begin
      if (slot == 3'(i)) begin
        r[(NUM_H - 1 - i) * 32 +: 32] = data;
      end else begin
        r[(NUM_H - 1 - i) * 32 +: 32] = r[(NUM_H - 1 - i) * 32 +: 32];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hk_lat_wait.sv
// Loadable down-counter: after each load it raises settled once LAT cycles
// have elapsed, i.e. when the memory read data reflects the new address.
module hk_lat_wait #(
  parameter int LAT = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic settled
);

  logic [1:0] cnt_r;

  // Count down from LAT towards zero; reload whenever a new address is issued
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_r <= 2'd0;
    end else if (load) begin
      cnt_r <= 2'(LAT);
    end else if (cnt_r != 2'd0) begin
      cnt_r <= cnt_r - 2'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign settled = (cnt_r == 2'd0);

endmodule

// File: rtl/hk_fetch_seq.sv
// Read-side sequencer for MOD_HK_MEM: loads the 8 initial hash words, then
// streams the 64 round constants over a valid/ready handshake.
module hk_fetch_seq
  import hk_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int AUTO_START = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         MEM_RDY,
  input  logic [31:0]  HK,
  output logic         HK_SELECTOR,
  output logic [2:0]   H_ADDR,
  output logic [5:0]   K_ADDR,
  output logic [255:0] H_WORDS,
  output logic         H_VALID,
  output logic [31:0]  K_WORD,
  output logic [5:0]   K_IDX,
  output logic         K_VALID,
  input  logic         K_READY,
  output logic         BUSY,
  output logic         DONE
);

  hk_state_e    state_r, state_nx_s;
  logic         hsel_r, hsel_nx_s;
  logic [2:0]   h_addr_r, h_addr_nx_s;
  logic [5:0]   k_addr_r, k_addr_nx_s;
  logic [255:0] h_words_r, h_words_nx_s;
  logic         h_valid_r, h_valid_nx_s;
  logic [31:0]  k_word_r, k_word_nx_s;
  logic [5:0]   k_idx_r, k_idx_nx_s;
  logic         k_valid_r, k_valid_nx_s;
  logic         busy_r, done_r;
  logic         lat_load_s, settled_s, abort_s, k_accept_s;

  hk_lat_wait #(.LAT(MEM_LAT)) u_lat_wait (
    .CLK     (CLK),
    .RST     (RST),
    .load    (lat_load_s),
    .settled (settled_s)
  );

  assign abort_s    = ((state_r == LOAD_H) || (state_r == STREAM_K)) && !MEM_RDY;
  assign k_accept_s = k_valid_r && K_READY;

  // Next-state and next register values for the whole sequencer
  always_comb begin
    state_nx_s   = state_r;
    hsel_nx_s    = hsel_r;
    h_addr_nx_s  = h_addr_r;
    k_addr_nx_s  = k_addr_r;
    h_words_nx_s = h_words_r;
    h_valid_nx_s = h_valid_r;
    k_word_nx_s  = k_word_r;
    k_idx_nx_s   = k_idx_r;
    k_valid_nx_s = k_valid_r;
    lat_load_s   = 1'b0;
    if (abort_s) begin
      state_nx_s   = WAIT_MEM;
      hsel_nx_s    = HSEL;
      h_addr_nx_s  = 3'd0;
      k_addr_nx_s  = 6'd0;
      h_valid_nx_s = 1'b0;
      k_valid_nx_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (START || (AUTO_START != 0)) begin
            state_nx_s   = WAIT_MEM;
            h_valid_nx_s = 1'b0;
          end else begin
            state_nx_s = IDLE;
          end
        end
        WAIT_MEM: begin
          hsel_nx_s   = HSEL;
          h_addr_nx_s = 3'd0;
          k_addr_nx_s = 6'd0;
          if (MEM_RDY) begin
            state_nx_s = LOAD_H;
            lat_load_s = 1'b1;
          end else begin
            state_nx_s = WAIT_MEM;
          end
        end
        LOAD_H: begin
          if (settled_s) begin
            h_words_nx_s = put_h_word(h_words_r, h_addr_r, HK);
            h_addr_nx_s  = h_addr_r + 3'd1;
            lat_load_s   = 1'b1;
            if (h_addr_r == 3'(NUM_H - 1)) begin
              h_valid_nx_s = 1'b1;
              hsel_nx_s    = KSEL;
              k_addr_nx_s  = 6'd0;
              state_nx_s   = STREAM_K;
            end else begin
              state_nx_s = LOAD_H;
            end
          end else begin
            state_nx_s = LOAD_H;
          end
        end
        STREAM_K: begin
          // K_ADDR runs one word ahead of K_IDX so a settled word can be
          // presented in the same edge the previous one is accepted.
          if (k_accept_s && (k_idx_r == 6'(NUM_K - 1))) begin
            k_valid_nx_s = 1'b0;
            k_addr_nx_s  = 6'd0;
            hsel_nx_s    = HSEL;
            state_nx_s   = FINISH;
          end else if ((!k_valid_r || k_accept_s) && settled_s) begin
            k_word_nx_s  = HK;
            k_idx_nx_s   = k_addr_r;
            k_valid_nx_s = 1'b1;
            k_addr_nx_s  = k_addr_r + 6'd1;
            lat_load_s   = 1'b1;
          end else if (k_accept_s) begin
            k_valid_nx_s = 1'b0;
          end else begin
            k_valid_nx_s = k_valid_r;
          end
        end
        FINISH: begin
          state_nx_s = IDLE;
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      hsel_r    <= HSEL;
      h_addr_r  <= 3'd0;
      k_addr_r  <= 6'd0;
      h_words_r <= 256'd0;
      h_valid_r <= 1'b0;
      k_word_r  <= 32'd0;
      k_idx_r   <= 6'd0;
      k_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      hsel_r    <= hsel_nx_s;
      h_addr_r  <= h_addr_nx_s;
      k_addr_r  <= k_addr_nx_s;
      h_words_r <= h_words_nx_s;
      h_valid_r <= h_valid_nx_s;
      k_word_r  <= k_word_nx_s;
      k_idx_r   <= k_idx_nx_s;
      k_valid_r <= k_valid_nx_s;
      busy_r    <= (state_nx_s != IDLE);
      done_r    <= (state_nx_s == FINISH);
    end
  end

  assign HK_SELECTOR = hsel_r;
  assign H_ADDR      = h_addr_r;
  assign K_ADDR      = k_addr_r;
  assign H_WORDS     = h_words_r;
  assign H_VALID     = h_valid_r;
  assign K_WORD      = k_word_r;
  assign K_IDX       = k_idx_r;
  assign K_VALID     = k_valid_r;
  assign BUSY        = busy_r;
  assign DONE        = done_r;

endmodule
